// File: rtl/pwm_deadtime.sv
// pwm_deadtime: per-channel complementary gate drive with programmable dead time
// and latched fault shutdown, configured over the peripheral write bus.
module pwm_deadtime #(
   parameter int NCH = 4,
   parameter int DTW = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             we_i,
   input  logic [31:0]      write_addr,
   input  logic [31:0]      write_data,
   input  logic [NCH-1:0]   pwm_in,
   input  logic             fault_i,
   output logic [NCH-1:0]   out_h,
   output logic [NCH-1:0]   out_l,
   output logic             fault_o
);
   localparam logic [31:0] DT_BASE   = 32'h0020_0000;
   localparam logic [31:0] DT_STRIDE = 32'h0001_0000;
   localparam logic [31:0] CTRL_ADDR = 32'h0024_0000;

   typedef enum logic [2:0] {OFF, LOW_ON, DEAD_TO_H, HIGH_ON, DEAD_TO_L} state_t;

   logic [DTW-1:0] r_dt [NCH];
   logic [NCH-1:0] r_en;
   logic [NCH-1:0] r_pwm;
   logic           r_fault;
   logic           w_ctrl_we;
   logic           w_unused;

   assign w_ctrl_we = we_i && write_addr == CTRL_ADDR;
   assign w_unused  = ^write_data[31:DTW];
   assign fault_o   = r_fault;

   always_ff @(posedge clk)
      if (rst) begin
         for (int k = 0; k < NCH; k++) r_dt[k] <= '0;
         r_en    <= '0;
         r_pwm   <= '0;
         r_fault <= 1'b0;
      end else begin
         r_pwm <= pwm_in;
         if (w_ctrl_we) r_en <= write_data[NCH-1:0];
         for (int k = 0; k < NCH; k++)
            if (we_i && write_addr == DT_BASE + 32'(k) * DT_STRIDE) r_dt[k] <= write_data[DTW-1:0];
         // a clear that coincides with an active fault loses
         r_fault <= fault_i | (r_fault & ~(w_ctrl_we & write_data[8]));
      end

   for (genvar i = 0; i < NCH; i++) begin : g_ch
      state_t         r_st;
      logic [DTW-1:0] r_cnt;
      always_ff @(posedge clk)
         if (rst) begin
            r_st  <= OFF;
            r_cnt <= '0;
         end else if (!r_en[i] || r_fault) begin
            r_st <= OFF;
         end else begin
            case (r_st)
               OFF: begin
                  r_st  <= r_pwm[i] ? DEAD_TO_H : DEAD_TO_L;
                  r_cnt <= r_dt[i];
               end
               LOW_ON: if (r_pwm[i]) begin
                  r_st  <= r_dt[i] == '0 ? HIGH_ON : DEAD_TO_H;
                  r_cnt <= r_dt[i];
               end
               HIGH_ON: if (!r_pwm[i]) begin
                  r_st  <= r_dt[i] == '0 ? LOW_ON : DEAD_TO_L;
                  r_cnt <= r_dt[i];
               end
               // a request that reverses mid-dead returns to the side that was on
               DEAD_TO_H:
                  if (!r_pwm[i]) r_st <= LOW_ON;
                  else if (r_cnt <= DTW'(1)) r_st <= HIGH_ON;
                  else r_cnt <= r_cnt - DTW'(1);
               DEAD_TO_L:
                  if (r_pwm[i]) r_st <= HIGH_ON;
                  else if (r_cnt <= DTW'(1)) r_st <= LOW_ON;
                  else r_cnt <= r_cnt - DTW'(1);
               default: r_st <= OFF;
            endcase
         end
      assign out_h[i] = r_st == HIGH_ON;
      assign out_l[i] = r_st == LOW_ON;
   end
endmodule

// File: tb/tb_pwm_deadtime.sv
// tb_pwm_deadtime: directed checks of dead-time insertion, abort, fault and reset.
module tb_pwm_deadtime;
   logic        clk, rst, we_i, fault_i, fault_o;
   logic [31:0] write_addr, write_data;
   logic [3:0]  pwm_in, out_h, out_l;
   int          checks = 0, errors = 0;
   logic        d1, d2, p;

   localparam logic [31:0] DT0 = 32'h0020_0000, DT1 = 32'h0021_0000, DT2 = 32'h0022_0000;
   localparam logic [31:0] DT3 = 32'h0023_0000, CTRL = 32'h0024_0000;

   pwm_deadtime #(.NCH(4), .DTW(16)) dut (
      .clk(clk), .rst(rst), .we_i(we_i), .write_addr(write_addr), .write_data(write_data),
      .pwm_in(pwm_in), .fault_i(fault_i), .out_h(out_h), .out_l(out_l), .fault_o(fault_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step(input int n = 1);
      repeat (n) @(negedge clk);
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      we_i = 1'b1; write_addr = a; write_data = d;
      @(negedge clk);
      we_i = 1'b0;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   always @(negedge clk)
      if (!rst) begin
         checks++;
         assert ((out_h & out_l) === 4'b0) else begin
            errors++;
            $error("FAIL overlap observed h=%b l=%b expected no common bit", out_h, out_l);
         end
      end

   initial begin
      rst = 1'b1; we_i = 1'b0; write_addr = '0; write_data = '0; fault_i = 1'b0; pwm_in = 4'hA;
      step(2);
      chk("reset", {7'b0, out_h, out_l, fault_o}, 16'h0);
      rst = 1'b0;
      for (int k = 0; k < 10; k++) begin
         pwm_in = 4'($urandom);
         step();
         chk("idle", {7'b0, out_h, out_l, fault_o}, 16'h0);
      end
      // channel 0, DT=3
      pwm_in = 4'h0;
      wr(DT0, 32'd3);
      wr(CTRL, 32'h1);
      for (int k = 0; k < 4; k++) begin chk("ch0_start_dead", 16'(out_l[0]), 16'h0); step(); end
      chk("ch0_low_on", 16'({out_h[0], out_l[0]}), 16'h1);
      pwm_in[0] = 1'b1;
      step();
      chk("ch0_rise_lag", 16'({out_h[0], out_l[0]}), 16'h1);
      step();
      for (int k = 0; k < 3; k++) begin chk("ch0_rise_dead", 16'({out_h[0], out_l[0]}), 16'h0); step(); end
      chk("ch0_high_on", 16'({out_h[0], out_l[0]}), 16'h2);
      pwm_in[0] = 1'b0;
      step();
      chk("ch0_fall_lag", 16'({out_h[0], out_l[0]}), 16'h2);
      step();
      for (int k = 0; k < 3; k++) begin chk("ch0_fall_dead", 16'({out_h[0], out_l[0]}), 16'h0); step(); end
      chk("ch0_low_again", 16'({out_h[0], out_l[0]}), 16'h1);
      // channel 1, DT=5, glitch aborts back to LOW_ON
      wr(DT1, 32'd5);
      wr(CTRL, 32'h3);
      step(6);
      chk("ch1_low_on", 16'({out_h[1], out_l[1]}), 16'h1);
      pwm_in[1] = 1'b1;
      step();
      chk("ch1_glitch_a", 16'({out_h[1], out_l[1]}), 16'h1);
      pwm_in[1] = 1'b0;
      step();
      chk("ch1_glitch_dead", 16'({out_h[1], out_l[1]}), 16'h0);
      for (int k = 0; k < 4; k++) begin
         step();
         chk("ch1_abort", 16'({out_h[1], out_l[1]}), 16'h1);
      end
      // channel 2, DT=0: follows with 2-cycle lag, no dead cycles
      wr(DT2, 32'd0);
      wr(CTRL, 32'h7);
      step(2);
      chk("ch2_low_on", 16'({out_h[2], out_l[2]}), 16'h1);
      d1 = 1'b0; d2 = 1'b0;
      for (int k = 0; k < 16; k++) begin
         p = ((k >> 2) & 1) == 0;
         pwm_in[2] = p;
         step();
         d2 = d1; d1 = p;
         chk("ch2_follow", 16'({out_h[2], out_l[2]}), 16'({d2, ~d2}));
      end
      wr(32'h0024_0004, 32'h0);
      step();
      chk("bad_addr_ignored", {8'b0, out_h, out_l}, 16'h07);
      // fault sequence
      wr(DT3, 32'd4);
      wr(CTRL, 32'hF);
      step(5);
      chk("all_low_on", {8'b0, out_h, out_l}, 16'h0F);
      fault_i = 1'b1;
      step();
      fault_i = 1'b0;
      chk("fault_latched", 16'(fault_o), 16'h1);
      step();
      chk("fault_outputs_off", {7'b0, out_h, out_l, fault_o}, 16'h1);
      step(3);
      chk("fault_held", {7'b0, out_h, out_l, fault_o}, 16'h1);
      fault_i = 1'b1;
      wr(CTRL, 32'h10F);
      fault_i = 1'b0;
      chk("clear_loses_to_set", 16'(fault_o), 16'h1);
      step();
      chk("fault_still_held", 16'(fault_o), 16'h1);
      wr(CTRL, 32'h10F);
      chk("fault_cleared", {7'b0, out_h, out_l, fault_o}, 16'h0);
      step(2);
      chk("resume_w2", {8'b0, out_h, out_l}, 16'h04);
      step();
      chk("resume_w3", {8'b0, out_h, out_l}, 16'h04);
      step();
      chk("resume_w4", {8'b0, out_h, out_l}, 16'h05);
      step();
      chk("resume_w5", {8'b0, out_h, out_l}, 16'h0D);
      step();
      chk("resume_w6", {8'b0, out_h, out_l}, 16'h0F);
      // DT3 rewritten mid-dead: current interval keeps 8, next uses 2
      wr(DT3, 32'd8);
      pwm_in[3] = 1'b1;
      step(2);
      wr(DT3, 32'd2);
      for (int k = 0; k < 7; k++) begin chk("ch3_dead8", 16'({out_h[3], out_l[3]}), 16'h0); step(); end
      chk("ch3_high_after8", 16'({out_h[3], out_l[3]}), 16'h2);
      pwm_in[3] = 1'b0;
      step();
      chk("ch3_fall_lag", 16'({out_h[3], out_l[3]}), 16'h2);
      step();
      chk("ch3_dead2_a", 16'({out_h[3], out_l[3]}), 16'h0);
      step();
      chk("ch3_dead2_b", 16'({out_h[3], out_l[3]}), 16'h0);
      step();
      chk("ch3_low_after2", 16'({out_h[3], out_l[3]}), 16'h1);
      pwm_in[3] = 1'b1;
      step(4);
      chk("ch3_high_again", 16'({out_h[3], out_l[3]}), 16'h2);
      wr(CTRL, 32'h7);
      step();
      chk("ch3_disabled", {8'b0, out_h, out_l}, 16'h07);
      // reset mid-operation
      fault_i = 1'b1;
      step();
      fault_i = 1'b0;
      chk("fault_before_rst", 16'(fault_o), 16'h1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("mid_reset", {7'b0, out_h, out_l, fault_o}, 16'h0);
      step(3);
      chk("post_reset_idle", {7'b0, out_h, out_l, fault_o}, 16'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
